sd_cmd_sequencer: RTL and testbench



---
 rtl/sd_pkg.sv | 39 +++
 rtl/sd_cmd_timer.sv | 35 +++
 rtl/sd_cmd_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_sd_cmd_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared encodings for the SD command sequencer: response types, completion
// status codes, the CMD55 index and the sequencer state enumeration.
package sd_pkg;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_R1   = 2'd1,
    RESP_R2   = 2'd2,
    RESP_R3   = 2'd3
  } resp_t;

  typedef enum logic [2:0] {
    STATUS_OK      = 3'd0,
    STATUS_TIMEOUT = 3'd1,
    STATUS_CRC_ERR = 3'd2,
    STATUS_APP_ERR = 3'd3
  } status_t;

  localparam logic [5:0] SD_CMD55 = 6'd55;

  typedef enum logic [3:0] {
    S_IDLE,
    S_APP_SEND,
    S_APP_TX,
    S_APP_RX,
    S_GAP,
    S_CMD_SEND,
    S_CMD_TX,
    S_CMD_RX,
    S_DONE
  } state_t;

  // A CMD55 reply is usable only if clean, echoing index 55, with APP_CMD set.
  function automatic logic app_resp_ok(input logic crc_err, input logic [5:0] echo_index,
                                       input logic app_cmd);
    return !crc_err && (echo_index == SD_CMD55) && app_cmd;
  endfunction

endpackage

// File: rtl/sd_cmd_timer.sv
// Shared down-counter for the response timeout and the inter-command gap;
// a load of N makes expired rise after exactly N cycles.
module sd_cmd_timer #(
  parameter int RESP_TIMEOUT = 64,
  parameter int CMD_GAP      = 8
) (
  input  logic ex_clk,
  input  logic clear,
  input  logic load_resp,
  input  logic load_gap,
  output logic expired
);

  localparam int MAX_LOAD = (RESP_TIMEOUT > CMD_GAP) ? RESP_TIMEOUT : CMD_GAP;
  localparam int W = $clog2(MAX_LOAD + 1);
  localparam logic [W-1:0] RESP_LOAD = W'(RESP_TIMEOUT - 1);
  localparam logic [W-1:0] GAP_LOAD  = W'(CMD_GAP - 1);

  logic [W-1:0] count_reg;

  always_ff @(posedge ex_clk) begin
    if (clear) begin
      count_reg <= '0;
    end else if (load_resp) begin
      count_reg <= RESP_LOAD;
    end else if (load_gap) begin
      count_reg <= GAP_LOAD;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/sd_cmd_sequencer.sv
// SD command engine: optional CMD55 prefix, launch, response collection with
// timeout, retry and N_CC gap. Define SD_CRC_RETRY_EN to make CMD CRC errors retry.
module sd_cmd_sequencer
  import sd_pkg::*;
#(
  parameter int RESP_TIMEOUT = 64,
  parameter int MAX_RETRY    = 3,
  parameter int CMD_GAP      = 8
) (
  input  logic         ex_clk,
  input  logic         reset,
  input  logic         software_reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [5:0]   req_index,
  input  logic [31:0]  req_arg,
  input  logic         req_app,
  input  logic [1:0]   req_resp,
  input  logic [15:0]  rca,
  output logic         send_en,
  output logic [37:0]  send_cmd_content,
  input  logic         sd_cmd_sending,
  output logic         receive_en,
  output logic         R2_response,
  input  logic         sd_receive_finished,
  input  logic         crc_response_err,
  input  logic [127:0] response,
  output logic         done_valid,
  output logic [2:0]   done_status,
  output logic [127:0] done_resp
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] MAX_RETRY_C = RW'(MAX_RETRY);

  logic clear;
  state_t state_reg, state_next, gap_target_reg, gap_target_next;
  status_t status_reg, status_next, done_status_reg, fail_status;
  logic [RW-1:0] retry_reg, retry_next;
  logic tx_first_reg;
  logic [5:0] index_reg;
  logic [31:0] arg_reg;
  logic app_reg;
  resp_t resp_reg;
  logic [15:0] rca_reg;
  logic [127:0] done_resp_reg;
  logic accept, latch_resp, fail, timer_expired, load_resp, load_gap;

  assign clear = reset | software_reset;

  always_comb begin
    state_next      = state_reg;
    gap_target_next = gap_target_reg;
    status_next     = status_reg;
    retry_next      = retry_reg;
    accept          = 1'b0;
    latch_resp      = 1'b0;
    fail            = 1'b0;
    fail_status     = STATUS_OK;
    case (state_reg)
      S_IDLE: begin
        if (req_valid) begin
          accept      = 1'b1;
          retry_next  = '0;
          status_next = STATUS_OK;
          state_next  = req_app ? S_APP_SEND : S_CMD_SEND;
        end
      end
      S_APP_SEND: state_next = S_APP_TX;
      S_CMD_SEND: state_next = S_CMD_TX;
      // Busy only rises one cycle after the launch, so the first TX cycle is blind.
      S_APP_TX: begin
        if (!tx_first_reg && !sd_cmd_sending) state_next = S_APP_RX;
      end
      S_CMD_TX: begin
        if (!tx_first_reg && !sd_cmd_sending) begin
          if (resp_reg == RESP_NONE) begin
            state_next      = S_GAP;
            gap_target_next = S_DONE;
            status_next     = STATUS_OK;
          end else begin
            state_next = S_CMD_RX;
          end
        end
      end
      S_APP_RX: begin
        if (sd_receive_finished) begin
          if (app_resp_ok(crc_response_err, response[37:32], response[5])) begin
            state_next      = S_GAP;
            gap_target_next = S_CMD_SEND;
          end else begin
            fail        = 1'b1;
            fail_status = STATUS_APP_ERR;
          end
        end else if (timer_expired) begin
          fail        = 1'b1;
          fail_status = STATUS_TIMEOUT;
        end
      end
      S_CMD_RX: begin
        if (sd_receive_finished) begin
          if (!crc_response_err || resp_reg == RESP_R3) begin
            latch_resp      = 1'b1;
            state_next      = S_GAP;
            gap_target_next = S_DONE;
            status_next     = STATUS_OK;
          end else begin
`ifdef SD_CRC_RETRY_EN
            fail        = 1'b1;
            fail_status = STATUS_CRC_ERR;
`else
            state_next  = S_DONE;
            status_next = STATUS_CRC_ERR;
`endif
          end
        end else if (timer_expired) begin
          fail        = 1'b1;
          fail_status = STATUS_TIMEOUT;
        end
      end
      S_GAP: begin
        if (timer_expired) state_next = gap_target_reg;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    if (fail) begin
      if (retry_reg < MAX_RETRY_C) begin
        retry_next      = retry_reg + RW'(1);
        state_next      = S_GAP;
        gap_target_next = app_reg ? S_APP_SEND : S_CMD_SEND;
      end else begin
        state_next  = S_DONE;
        status_next = fail_status;
      end
    end
  end

  assign load_resp = (state_next != state_reg) &&
                     (state_next == S_APP_RX || state_next == S_CMD_RX);
  assign load_gap  = (state_next != state_reg) && (state_next == S_GAP);

  sd_cmd_timer #(
    .RESP_TIMEOUT (RESP_TIMEOUT),
    .CMD_GAP      (CMD_GAP)
  ) u_timer (
    .ex_clk    (ex_clk),
    .clear     (clear),
    .load_resp (load_resp),
    .load_gap  (load_gap),
    .expired   (timer_expired)
  );

  always_ff @(posedge ex_clk) begin
    if (clear) begin
      state_reg       <= S_IDLE;
      gap_target_reg  <= S_IDLE;
      status_reg      <= STATUS_OK;
      done_status_reg <= STATUS_OK;
      retry_reg       <= '0;
      tx_first_reg    <= 1'b0;
      index_reg       <= '0;
      arg_reg         <= '0;
      app_reg         <= 1'b0;
      resp_reg        <= RESP_NONE;
      rca_reg         <= '0;
      done_resp_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      gap_target_reg <= gap_target_next;
      status_reg     <= status_next;
      retry_reg      <= retry_next;
      tx_first_reg   <= (state_reg == S_APP_SEND) || (state_reg == S_CMD_SEND);
      if (accept) begin
        index_reg <= req_index;
        arg_reg   <= req_arg;
        app_reg   <= req_app;
        resp_reg  <= resp_t'(req_resp);
        rca_reg   <= rca;
      end
      if (latch_resp) done_resp_reg <= response;
      if (state_next == S_DONE && state_reg != S_DONE) done_status_reg <= status_next;
    end
  end

  assign req_ready        = (state_reg == S_IDLE);
  assign send_en          = (state_reg == S_APP_SEND) || (state_reg == S_CMD_SEND);
  assign send_cmd_content = (state_reg == S_APP_SEND) ? {SD_CMD55, rca_reg, 16'h0000}
                                                      : {index_reg, arg_reg};
  assign receive_en       = (state_reg == S_APP_RX) || (state_reg == S_CMD_RX);
  assign R2_response      = (state_reg == S_CMD_RX) && (resp_reg == RESP_R2);
  assign done_valid       = (state_reg == S_DONE);
  assign done_status      = done_status_reg;
  assign done_resp        = done_resp_reg;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Scoreboard bench for sd_cmd_sequencer with a busy-driver and scripted receiver model.
module tb_sd_cmd_sequencer;

  localparam int BUSY = 3;

  logic         ex_clk = 1'b0;
  logic         reset = 1'b1;
  logic         software_reset = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [5:0]   req_index = '0;
  logic [31:0]  req_arg = '0;
  logic         req_app = 1'b0;
  logic [1:0]   req_resp = '0;
  logic [15:0]  rca = '0;
  logic         send_en;
  logic [37:0]  send_cmd_content;
  logic         sd_cmd_sending = 1'b0;
  logic         receive_en;
  logic         R2_response;
  logic         sd_receive_finished = 1'b0;
  logic         crc_response_err = 1'b0;
  logic [127:0] response = '0;
  logic         done_valid;
  logic [2:0]   done_status;
  logic [127:0] done_resp;

  always #5 ex_clk = ~ex_clk;

  sd_cmd_sequencer dut (
    .ex_clk (ex_clk), .reset (reset), .software_reset (software_reset),
    .req_valid (req_valid), .req_ready (req_ready), .req_index (req_index),
    .req_arg (req_arg), .req_app (req_app), .req_resp (req_resp), .rca (rca),
    .send_en (send_en), .send_cmd_content (send_cmd_content),
    .sd_cmd_sending (sd_cmd_sending), .receive_en (receive_en),
    .R2_response (R2_response), .sd_receive_finished (sd_receive_finished),
    .crc_response_err (crc_response_err), .response (response),
    .done_valid (done_valid), .done_status (done_status), .done_resp (done_resp)
  );

  typedef struct { logic [37:0] content; int cyc; } send_exp_t;
  typedef struct { logic [2:0] status; logic [127:0] resp; int cyc; } done_exp_t;
  typedef struct { bit fin; int dly; bit crc; logic [127:0] rsp; } rx_act_t;

  send_exp_t send_q[$];
  done_exp_t done_q[$];
  rx_act_t   rx_q[$];

  int cyc = 0, checks = 0, fails = 0, r2_cnt = 0;

  localparam logic [127:0] APP_OK  = 128'h0000_0000_0000_0000_0000_0037_0000_0020;
  localparam logic [127:0] APP_BAD = 128'h0000_0000_0000_0000_0000_0037_0000_0000;
  localparam logic [127:0] R3_VAL  = 128'h0000_0000_0000_0000_0000_3F80_FF80_00FF;
  localparam logic [127:0] R2_VAL  = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
  localparam logic [127:0] CRC_VAL = 128'h0000_0000_0000_0000_0000_0D00_0009_0001;

  always @(posedge ex_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT launches or completes.
  initial begin : monitor
    send_exp_t se;
    done_exp_t de;
    forever begin
      @(negedge ex_clk);
      if (R2_response) r2_cnt++;
      if (send_en) begin
        if (send_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_send: got content %h at cycle %0d, required no launch", send_cmd_content, cyc);
        end else begin
          se = send_q.pop_front();
          check("send_content", 128'(send_cmd_content), 128'(se.content));
          check("send_cycle", 128'(cyc), 128'(se.cyc));
          $display("send  content=%h cycle=%0d", send_cmd_content, cyc);
        end
      end
      if (done_valid) begin
        if (done_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_done: got status %0d at cycle %0d, required no completion", done_status, cyc);
        end else begin
          de = done_q.pop_front();
          check("done_status", 128'(done_status), 128'(de.status));
          check("done_resp", done_resp, de.resp);
          check("done_cycle", 128'(cyc), 128'(de.cyc));
          $display("done  status=%0d resp=%h cycle=%0d", done_status, done_resp, cyc);
        end
      end
    end
  end

  // sd_send model: busy for BUSY-1 cycles after the one-cycle blind window.
  initial begin : driver
    int busy_left;
    busy_left = 0;
    forever begin
      @(negedge ex_clk);
      if (send_en) busy_left = BUSY;
      else if (busy_left > 0) busy_left--;
      sd_cmd_sending = (busy_left != 0);
    end
  end

  // sd_receive model: finishes in RX cycle dly of each armed window, or never.
  initial begin : responder
    rx_act_t act;
    bit armed;
    int cnt;
    armed = 0;
    cnt = 0;
    act = '{fin: 0, dly: 0, crc: 0, rsp: '0};
    forever begin
      @(negedge ex_clk);
      sd_receive_finished = 1'b0;
      crc_response_err = 1'b0;
      if (!receive_en) begin
        armed = 0;
      end else begin
        if (!armed) begin
          armed = 1;
          cnt = 0;
          if (rx_q.size() > 0) act = rx_q.pop_front();
          else act = '{fin: 0, dly: 0, crc: 0, rsp: '0};
        end
        cnt++;
        if (act.fin && cnt == act.dly) begin
          sd_receive_finished = 1'b1;
          crc_response_err = act.crc;
          response = act.rsp;
        end
      end
    end
  end

  task automatic start(input logic [5:0] idx, input logic [31:0] arg, input logic app,
                       input logic [1:0] rt, input logic [15:0] r, output int a);
    @(negedge ex_clk);
    check("req_ready_idle", 128'(req_ready), 128'(1));
    req_index = idx; req_arg = arg; req_app = app; req_resp = rt; rca = r;
    req_valid = 1'b1;
    a = cyc;
  endtask

  task automatic finish_req();
    @(negedge ex_clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((send_q.size() != 0 || done_q.size() != 0) && n < budget) begin
      @(negedge ex_clk);
      n++;
    end
    checks++;
    if (send_q.size() != 0 || done_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d launches and %0d completions outstanding, required 0",
               send_q.size(), done_q.size());
      send_q.delete();
      done_q.delete();
    end
    repeat (2) @(negedge ex_clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of test, required completion within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int a;
    int n;
    logic [127:0] hold;
    hold = '0;

    repeat (3) @(negedge ex_clk);
    check("rst_req_ready", 128'(req_ready), 128'(1));
    check("rst_send_en", 128'(send_en), 128'(0));
    check("rst_receive_en", 128'(receive_en), 128'(0));
    check("rst_r2", 128'(R2_response), 128'(0));
    check("rst_done_valid", 128'(done_valid), 128'(0));
    check("rst_content", 128'(send_cmd_content), 128'(0));
    check("rst_done_status", 128'(done_status), 128'(0));
    check("rst_done_resp", done_resp, 128'(0));
    reset = 1'b0;

    // CMD0, no response: launch next cycle, done after TX + 8-cycle gap.
    start(6'd0, 32'h0, 1'b0, 2'd0, 16'h0, a);
    send_q.push_back('{content: 38'h0, cyc: a + 1});
    done_q.push_back('{status: 3'd0, resp: hold, cyc: a + 13});
    finish_req();
    wait_drain(100);

    // ACMD41 with R3 and a CRC error that must be ignored.
    r2_cnt = 0;
    rx_q.push_back('{fin: 1, dly: 2, crc: 0, rsp: APP_OK});
    rx_q.push_back('{fin: 1, dly: 3, crc: 1, rsp: R3_VAL});
    start(6'd41, 32'h40FF8000, 1'b1, 2'd3, 16'h0, a);
    send_q.push_back('{content: {6'd55, 32'h0}, cyc: a + 1});
    send_q.push_back('{content: {6'd41, 32'h40FF8000}, cyc: a + 15});
    hold = R3_VAL;
    done_q.push_back('{status: 3'd0, resp: hold, cyc: a + 30});
    finish_req();
    wait_drain(100);
    check("r2_cycles_r3", 128'(r2_cnt), 128'(0));

    // CMD2 with R2: R2_response only across the 5 CMD_RX cycles.
    r2_cnt = 0;
    rx_q.push_back('{fin: 1, dly: 5, crc: 0, rsp: R2_VAL});
    start(6'd2, 32'h0, 1'b0, 2'd2, 16'h0, a);
    send_q.push_back('{content: {6'd2, 32'h0}, cyc: a + 1});
    hold = R2_VAL;
    done_q.push_back('{status: 3'd0, resp: hold, cyc: a + 18});
    finish_req();
    wait_drain(100);
    check("r2_cycles_r2", 128'(r2_cnt), 128'(5));

    // No response at all: four launches 76 cycles apart, then TIMEOUT.
    start(6'd17, 32'h00000200, 1'b0, 2'd1, 16'h0, a);
    for (int k = 0; k < 4; k++)
      send_q.push_back('{content: {6'd17, 32'h00000200}, cyc: a + 1 + 76 * k});
    done_q.push_back('{status: 3'd1, resp: hold, cyc: a + 297});
    finish_req();
    wait_drain(400);

    // CMD55 reply without APP_CMD every time: APP_ERR and no CMD41 launch.
    for (int k = 0; k < 4; k++) rx_q.push_back('{fin: 1, dly: 1, crc: 0, rsp: APP_BAD});
    start(6'd41, 32'h00FF8000, 1'b1, 2'd1, 16'h1234, a);
    for (int k = 0; k < 4; k++)
      send_q.push_back('{content: {6'd55, 32'h12340000}, cyc: a + 1 + 13 * k});
    done_q.push_back('{status: 3'd3, resp: hold, cyc: a + 45});
    finish_req();
    wait_drain(100);

    // Hard and software reset while waiting for a response.
    for (int ri = 0; ri < 2; ri++) begin
      start(6'd9, 32'h12340000, 1'b0, 2'd1, 16'h0, a);
      send_q.push_back('{content: {6'd9, 32'h12340000}, cyc: a + 1});
      finish_req();
      n = 0;
      while (!receive_en && n < 20) begin
        @(negedge ex_clk);
        n++;
      end
      check("rx_armed_before_reset", 128'(receive_en), 128'(1));
      if (ri == 0) reset = 1'b1;
      else software_reset = 1'b1;
      @(negedge ex_clk);
      check("abort_req_ready", 128'(req_ready), 128'(1));
      check("abort_receive_en", 128'(receive_en), 128'(0));
      check("abort_send_en", 128'(send_en), 128'(0));
      check("abort_done_resp", done_resp, 128'(0));
      reset = 1'b0;
      software_reset = 1'b0;
      hold = '0;
      repeat (100) @(negedge ex_clk);
      wait_drain(10);
    end

    // R1 CRC error in CMD_RX.
`ifdef SD_CRC_RETRY_EN
    for (int k = 0; k < 4; k++) rx_q.push_back('{fin: 1, dly: 2, crc: 1, rsp: CRC_VAL});
    start(6'd13, 32'h00010000, 1'b0, 2'd1, 16'h0, a);
    for (int k = 0; k < 4; k++)
      send_q.push_back('{content: {6'd13, 32'h00010000}, cyc: a + 1 + 14 * k});
    done_q.push_back('{status: 3'd2, resp: hold, cyc: a + 49});
`else
    rx_q.push_back('{fin: 1, dly: 2, crc: 1, rsp: CRC_VAL});
    start(6'd13, 32'h00010000, 1'b0, 2'd1, 16'h0, a);
    send_q.push_back('{content: {6'd13, 32'h00010000}, cyc: a + 1});
    done_q.push_back('{status: 3'd2, resp: hold, cyc: a + 7});
`endif
    finish_req();
    wait_drain(200);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
